// File: rtl/vga_pkg.sv
// Shared VGA definitions: state codes, display modes and
// bus timing defaults used by both the VGA block and its masters.
package vga_pkg;

  localparam int RD_HOLD_DEF = 4;
  localparam int WR_HOLD_DEF = 6;
  localparam int RECOVER_DEF = 2;

  typedef enum logic [1:0] {
    MODE_TEXT    = 2'd0,
    MODE_320X200 = 2'd1,
    MODE_320X400 = 2'd2,
    MODE_640X200 = 2'd3
  } vga_mode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_SETUP = 3'd1;
  localparam logic [2:0] PH_RD    = 3'd2;
  localparam logic [2:0] PH_WR    = 3'd3;
  localparam logic [2:0] PH_REC   = 3'd4;

endpackage

// File: rtl/vga_blit_master_if.sv
// VGA memory port plus HOLD/HLDA request pair, as seen
// by a bus initiator (master) and the VGA/arbiter side (slave).
interface vga_blit_master_if #(
  parameter int ADDR_W = 17
);

  logic              bus_req;
  logic              bus_gnt;
  logic              _vga_mem;
  logic [ADDR_W-1:0] bus_addr;
  logic              _rd;
  logic              _wr;
  logic              _bhe;
  logic              rdy;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              data_oe;

  modport master (
    output bus_req, _vga_mem, bus_addr,
    output _rd, _wr, _bhe, data_out, data_oe,
    input  bus_gnt, rdy, data_in
  );

  modport slave (
    input  bus_req, _vga_mem, bus_addr,
    input  _rd, _wr, _bhe, data_out, data_oe,
    output bus_gnt, rdy, data_in
  );

endinterface

// File: rtl/vga_bus_access.sv
// One VGA word access: SETUP, strobe held until rdy has been
// stable long enough, then RECOVER idle cycles to re-arm the slave.
module vga_bus_access
  import vga_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int RD_HOLD = RD_HOLD_DEF,
  parameter int WR_HOLD = WR_HOLD_DEF,
  parameter int RECOVER = RECOVER_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              go_rd,
  input  logic [ADDR_W-1:0] go_addr,
  input  logic [15:0]       go_wdata,
  input  logic              rdy,
  input  logic [15:0]       data_in,
  output logic              wr_fin,
  output logic              fin,
  output logic [15:0]       rdata,
  output logic              vga_mem_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              bhe_n,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       wdata,
  output logic              data_oe
);

  localparam logic [7:0] RD_T  = 8'(RD_HOLD - 1);
  localparam logic [7:0] WR_T  = 8'(WR_HOLD - 1);
  localparam logic [7:0] REC_T = 8'(RECOVER - 1);
  localparam logic [ADDR_W-1:0] EVEN = ~ADDR_W'(1);

  logic [2:0] ph;
  logic [1:0] rdy_q;
  logic       rdy_s;
  logic       is_rd;
  logic [7:0] cnt;
  logic [7:0] rec_cnt;
  logic       oe_rec;
  logic       rd_hit;
  logic       take;
  logic       in_acc;

  assign rdy_s  = rdy_q[1];
  assign rd_hit = (ph == PH_RD) && rdy_s && (cnt == RD_T);
  assign wr_fin = (ph == PH_WR) && rdy_s && (cnt == WR_T);
  assign fin    = (ph == PH_REC) && (rec_cnt == REC_T);
  assign take   = go && ((ph == PH_IDLE) || fin);

  assign in_acc = (ph == PH_SETUP) || (ph == PH_RD)
               || (ph == PH_WR);

  assign vga_mem_n = !in_acc;
  assign bhe_n     = !in_acc;
  assign rd_n      = !(ph == PH_RD);
  assign wr_n      = !(ph == PH_WR);
  assign data_oe   = ((ph == PH_SETUP) && !is_rd)
                  || (ph == PH_WR) || oe_rec;

  // rdy comes from the VGA clock domain: two-flop sync
  always_ff @(posedge clock) begin
    if (reset) rdy_q <= 2'b00;
    else       rdy_q <= {rdy_q[0], rdy};
  end

  // access phase sequencing and hold counter
  always_ff @(posedge clock) begin
    if (reset) begin
      ph      <= PH_IDLE;
      is_rd   <= 1'b0;
      cnt     <= 8'd0;
      rec_cnt <= 8'd0;
      oe_rec  <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
    end else begin
      oe_rec <= wr_fin;
      if (take) begin
        addr  <= go_addr & EVEN;
        wdata <= go_wdata;
        is_rd <= go_rd;
      end
      unique case (ph)
        PH_IDLE: begin
          if (go) ph <= PH_SETUP;
        end
        PH_SETUP: begin
          cnt <= 8'd0;
          ph  <= is_rd ? PH_RD : PH_WR;
        end
        PH_RD: begin
          if (rd_hit) begin
            rdata   <= data_in;
            rec_cnt <= 8'd0;
            ph      <= PH_REC;
          end else begin
            cnt <= rdy_s ? cnt + 8'd1 : 8'd0;
          end
        end
        PH_WR: begin
          if (wr_fin) begin
            rec_cnt <= 8'd0;
            ph      <= PH_REC;
          end else begin
            cnt <= rdy_s ? cnt + 8'd1 : 8'd0;
          end
        end
        PH_REC: begin
          if (fin) ph <= go ? PH_SETUP : PH_IDLE;
          else     rec_cnt <= rec_cnt + 8'd1;
        end
        default: ph <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_blit_master.sv
// Fill/copy engine mastering the VGA memory port: owns operands,
// word count and bus request; vga_bus_access runs each access.
module vga_blit_master
  import vga_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int LEN_W   = 16,
  parameter int RD_HOLD = RD_HOLD_DEF,
  parameter int WR_HOLD = WR_HOLD_DEF,
  parameter int RECOVER = RECOVER_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              copy_mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [15:0]       fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  vga_blit_master_if.master bus
);

  localparam logic [ADDR_W-1:0] EVEN = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(2);

  logic [1:0]        state;
  logic [1:0]        gnt_q;
  logic              gnt_s;
  logic              req;
  logic              copy_l;
  logic              abort_l;
  logic              pend_wr;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  remain;
  logic [15:0]       fill_l;

  logic              go;
  logic              go_rd;
  logic [ADDR_W-1:0] go_addr;
  logic              wr_fin;
  logic              fin;
  logic [15:0]       rdata;

  assign gnt_s       = gnt_q[1];
  assign bus.bus_req = req;

  vga_bus_access #(
    .ADDR_W  (ADDR_W),
    .RD_HOLD (RD_HOLD),
    .WR_HOLD (WR_HOLD),
    .RECOVER (RECOVER)
  ) u_acc (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .go_rd     (go_rd),
    .go_addr   (go_addr),
    .go_wdata  (copy_l ? rdata : fill_l),
    .rdy       (bus.rdy),
    .data_in   (bus.data_in),
    .wr_fin    (wr_fin),
    .fin       (fin),
    .rdata     (rdata),
    .vga_mem_n (bus._vga_mem),
    .rd_n      (bus._rd),
    .wr_n      (bus._wr),
    .bhe_n     (bus._bhe),
    .addr      (bus.bus_addr),
    .wdata     (bus.data_out),
    .data_oe   (bus.data_oe)
  );

  // next access launch: pending copy write always goes first
  always_comb begin
    go      = 1'b0;
    go_rd   = 1'b0;
    go_addr = dst;
    unique case (state)
      ST_REQ: begin
        if (gnt_s && !abort_l) begin
          go      = 1'b1;
          go_rd   = copy_l;
          go_addr = copy_l ? src : dst;
        end
      end
      ST_XFER: begin
        if (fin) begin
          if (pend_wr) begin
            go = 1'b1;
          end else if (remain != '0 && !abort_l && gnt_s) begin
            go      = 1'b1;
            go_rd   = copy_l;
            go_addr = copy_l ? src : dst;
          end
        end
      end
      default: ;
    endcase
  end

  // HLDA is asynchronous: two-flop sync
  always_ff @(posedge clock) begin
    if (reset) gnt_q <= 2'b00;
    else       gnt_q <= {gnt_q[0], bus.bus_gnt};
  end

  // transfer control, operands and word count
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      req     <= 1'b0;
      copy_l  <= 1'b0;
      abort_l <= 1'b0;
      pend_wr <= 1'b0;
      src     <= '0;
      dst     <= '0;
      remain  <= '0;
      fill_l  <= '0;
    end else begin
      done <= 1'b0;
      if (go) pend_wr <= go_rd;
      if (busy && abort) abort_l <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          abort_l <= 1'b0;
          if (start) begin
            if (len != '0) begin
              copy_l <= copy_mode;
              src    <= src_addr & EVEN;
              dst    <= dst_addr & EVEN;
              remain <= len;
              fill_l <= fill_val;
              busy   <= 1'b1;
              req    <= 1'b1;
              state  <= ST_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (abort_l)    state <= ST_DONE;
          else if (gnt_s) state <= ST_XFER;
        end
        ST_XFER: begin
          if (wr_fin) begin
            remain <= remain - LEN_W'(1);
            src    <= src + STEP;
            dst    <= dst + STEP;
          end
          if (fin && !pend_wr && !go) begin
            state <= (remain == '0 || abort_l)
                   ? ST_DONE : ST_REQ;
          end
        end
        ST_DONE: begin
          req     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          abort_l <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_blit_master.sv
// Directed bench for vga_blit_master: model VGA memory, delayed
// grant, and a write scoreboard checked as writes complete.
module tb_vga_blit_master;
  import vga_pkg::*;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        copy_mode;
  logic [16:0] src_addr;
  logic [16:0] dst_addr;
  logic [15:0] len;
  logic [15:0] fill_val;
  logic        abort;
  logic        busy;
  logic        done;

  vga_blit_master_if #(.ADDR_W(17)) bus ();

  vga_blit_master dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .copy_mode (copy_mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_val  (fill_val),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] vmem [65536];
  assign bus.data_in = vmem[bus.bus_addr[16:1]];

  wr_t sb [$];
  int  rd_lens [$];
  int  wr_lens [$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_wr = 0;
  int  n_rd = 0;
  int  n_done = 0;
  int  gnt_delay = 5;
  bit  req_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [16:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic go_xfer(input logic cm, input logic [16:0] s,
                         input logic [16:0] d, input logic [15:0] l,
                         input logic [15:0] f);
    @(negedge clock);
    copy_mode = cm;
    src_addr  = s;
    dst_addr  = d;
    len       = l;
    fill_val  = f;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int i = 0;
    while (done !== 1'b1 && i < lim) begin
      @(negedge clock);
      i++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, bus.bus_req, 0);
  endtask

  // grant model: HLDA follows HOLD after gnt_delay cycles
  initial begin
    int gcnt = 0;
    bus.bus_gnt = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.bus_req !== 1'b1) begin
        bus.bus_gnt = 1'b0;
        gcnt = 0;
      end else if (!bus.bus_gnt) begin
        gcnt++;
        if (gcnt >= gnt_delay) bus.bus_gnt = 1'b1;
      end
    end
  end

  // bus monitor: strobe widths, recovery gaps, scoreboard pops
  initial begin
    int wr_len = 0;
    int rd_len = 0;
    int gap = 100;
    logic wr_prev = 1'b1;
    logic rd_prev = 1'b1;
    logic mem_prev = 1'b1;
    logic oe_ok = 1'b1;
    logic [16:0] wa = '0;
    logic [15:0] wd = '0;
    wr_t e;
    forever begin
      @(negedge clock);
      if (bus._wr === 1'b0) begin
        wr_len++;
        wa = bus.bus_addr;
        wd = bus.data_out;
        if (bus.data_oe !== 1'b1) oe_ok = 1'b0;
      end else if (wr_prev === 1'b0) begin
        if (!reset) begin
          n_wr++;
          wr_lens.push_back(wr_len);
          chk("wr_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_addr", wa, e.addr);
            chk("wr_data", wd, e.data);
          end
          chk("wr_hold", wr_len >= WR_HOLD_DEF, 1);
          chk("wr_oe", oe_ok, 1);
          vmem[wa[16:1]] = wd;
        end
        wr_len = 0;
        oe_ok = 1'b1;
      end
      if (bus._rd === 1'b0) begin
        rd_len++;
      end else if (rd_prev === 1'b0) begin
        if (!reset) begin
          n_rd++;
          rd_lens.push_back(rd_len);
          chk("rd_hold", rd_len >= RD_HOLD_DEF, 1);
        end
        rd_len = 0;
      end
      if (bus._vga_mem !== 1'b0) begin
        gap++;
      end else begin
        if (mem_prev === 1'b1 && !reset)
          chk("rec_gap", gap >= RECOVER_DEF, 1);
        gap = 0;
      end
      wr_prev  = bus._wr;
      rd_prev  = bus._rd;
      mem_prev = bus._vga_mem;
      if (done === 1'b1) n_done++;
      if (bus.bus_req === 1'b1) req_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw0;
    int nr0;
    int nd0;
    logic [15:0] e0;
    logic [15:0] e1;
    reset = 1'b1; start = 1'b0; copy_mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    bus.rdy = 1'b1;
    for (int i = 0; i < 65536; i++)
      vmem[i] = 16'(i * 7) ^ 16'hA55A;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus.bus_req, 0);
    chk("rst_mem", bus._vga_mem, 1);
    chk("rst_rd", bus._rd, 1);
    chk("rst_wr", bus._wr, 1);
    chk("rst_bhe", bus._bhe, 1);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_oe", bus.data_oe, 0);
    reset = 1'b0;

    // fill three words
    nw0 = n_wr; nd0 = n_done;
    push(17'h00100, 16'hA5A5);
    push(17'h00102, 16'hA5A5);
    push(17'h00104, 16'hA5A5);
    go_xfer(1'b0, 17'h0, 17'h00100, 16'd3, 16'hA5A5);
    wait_done("fill", 500);
    chk("fill_nwr", n_wr - nw0, 3);
    chk("fill_sb", sb.size(), 0);
    @(negedge clock);
    chk("fill_pulse", done, 0);
    @(negedge clock);
    chk("fill_ndone", n_done - nd0, 1);

    // copy with rdy stalls in RD and WR
    rd_lens.delete(); wr_lens.delete();
    e0 = vmem[16'h0000]; e1 = vmem[16'h0001];
    push(17'h04000, e0);
    push(17'h04002, e1);
    go_xfer(1'b1, 17'h00000, 17'h04000, 16'd2, 16'h0);
    for (int i = 0; i < 300 && bus._rd !== 1'b0; i++)
      @(negedge clock);
    chk("cp_rd_seen", bus._rd, 0);
    bus.rdy = 1'b0;
    repeat (10) @(negedge clock);
    bus.rdy = 1'b1;
    for (int i = 0; i < 300 && bus._wr !== 1'b0; i++)
      @(negedge clock);
    chk("cp_wr_seen", bus._wr, 0);
    bus.rdy = 1'b0;
    repeat (7) @(negedge clock);
    bus.rdy = 1'b1;
    wait_done("copy", 1000);
    chk("cp_nrd", rd_lens.size(), 2);
    chk("cp_nwr", wr_lens.size(), 2);
    chk("cp_rd_stall", rd_lens[0] >= RD_HOLD_DEF + 10, 1);
    chk("cp_wr_stall", wr_lens[0] >= WR_HOLD_DEF + 7, 1);
    chk("cp_sb", sb.size(), 0);
    chk("cp_mem0", vmem[16'h2000], e0);
    chk("cp_mem1", vmem[16'h2001], e1);

    // zero length
    req_seen = 1'b0; nw0 = n_wr;
    go_xfer(1'b0, 17'h0, 17'h00500, 16'd0, 16'h1111);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    @(negedge clock);
    chk("len0_pulse", done, 0);
    repeat (5) @(negedge clock);
    chk("len0_noreq", req_seen, 0);
    chk("len0_nwr", n_wr - nw0, 0);

    // address wrap
    nw0 = n_wr;
    push(17'h1FFFE, 16'h5A5A);
    push(17'h00000, 16'h5A5A);
    go_xfer(1'b0, 17'h0, 17'h1FFFE, 16'd2, 16'h5A5A);
    wait_done("wrap", 500);
    chk("wrap_nwr", n_wr - nw0, 2);
    chk("wrap_sb", sb.size(), 0);
    chk("wrap_mem", vmem[16'hFFFF], 16'h5A5A);

    // abort during RD of word 2 of a 5-word copy
    nw0 = n_wr; nr0 = n_rd;
    e0 = vmem[16'h0100]; e1 = vmem[16'h0101];
    push(17'h00800, e0);
    push(17'h00802, e1);
    go_xfer(1'b1, 17'h00200, 17'h00800, 16'd5, 16'h0);
    for (int i = 0; i < 2000 &&
         !((n_rd - nr0) == 1 && bus._rd === 1'b0); i++)
      @(negedge clock);
    chk("ab_rd2", bus._rd, 0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_done("abort", 1000);
    repeat (10) @(negedge clock);
    chk("ab_nrd", n_rd - nr0, 2);
    chk("ab_nwr", n_wr - nw0, 2);
    chk("ab_sb", sb.size(), 0);
    chk("ab_mem", vmem[16'h0401], e1);

    // reset while _wr is low, then a normal transfer
    push(17'h03000, 16'hBEEF);
    go_xfer(1'b0, 17'h0, 17'h03000, 16'd4, 16'hBEEF);
    for (int i = 0; i < 300 && bus._wr !== 1'b0; i++)
      @(negedge clock);
    chk("rs_wr_seen", bus._wr, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rs_wr", bus._wr, 1);
    chk("rs_mem", bus._vga_mem, 1);
    chk("rs_req", bus.bus_req, 0);
    chk("rs_busy", busy, 0);
    @(negedge clock);
    sb.delete();
    reset = 1'b0;
    nw0 = n_wr;
    push(17'h00040, 16'h7777);
    go_xfer(1'b0, 17'h0, 17'h00040, 16'd1, 16'h7777);
    wait_done("post", 500);
    chk("post_nwr", n_wr - nw0, 1);
    chk("post_sb", sb.size(), 0);
    chk("post_mem", vmem[16'h0020], 16'h7777);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_blit_master.md
Name: vga_blit_master

Overview:
- Bus-master fill/copy engine. It is the initiator side of the VGA memory port: it drives _vga_mem, addr, _rd, _wr and _bhe, and honours rdy, exactly as the CPU does.
- It requests the system bus with a HOLD/HLDA-style handshake, then performs word reads and writes into VGA RAM.
- Purpose: rectangle clears and scrolls without CPU copy loops.

Parameters:
- ADDR_W, 17, byte-address width of VGA window (bit 0 always driven 0).
- LEN_W, 16, transfer length width in 16-bit words.
- RD_HOLD, 4, consecutive rdy-high cycles required before read data is captured.
- WR_HOLD, 6, consecutive rdy-high cycles required before _wr is released. Must cover VGA-side 1-cycle input sync plus the 3-cycle write delay.
- RECOVER, 2, idle cycles with all strobes high between accesses.

Ports:
- clock  in  1  50 MHz system clock, same as the VGA block.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; ignored unless busy=0.
- copy_mode  in  1  1 = copy src to dst, 0 = fill dst with fill_val.
- src_addr  in  ADDR_W  source byte address; sampled at start.
- dst_addr  in  ADDR_W  destination byte address; sampled at start.
- len  in  LEN_W  number of words; sampled at start.
- fill_val  in  16  fill word; sampled at start.
- abort  in  1  stop after the current access completes.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion or abort.
- bus_req  out  1  system bus request (HOLD).
- bus_gnt  in  1  bus grant (HLDA), asynchronous.
- _vga_mem  out  1  VGA memory select, active-low.
- bus_addr  out  ADDR_W  byte address; [1:0] feed the VGA addr inputs.
- _rd  out  1  read strobe, active-low.
- _wr  out  1  write strobe, active-low.
- _bhe  out  1  byte-high enable, active-low.
- rdy  in  1  VGA ready, asynchronous.
- data_in  in  16  read data from the data bus.
- data_out  out  16  write data.
- data_oe  out  1  drive data_out onto the data bus.

Behaviour:
- Reset values:
  - busy, done, bus_req, data_oe = 0.
  - _vga_mem, _rd, _wr, _bhe = 1.
  - bus_addr, data_out = 0.
  - State = IDLE.
- Reset mid-transfer releases all strobes and bus_req in the same cycle.
- Synchronisation: rdy and bus_gnt each pass through a 2-flop synchroniser. "rdy_s" and "gnt_s" below mean the synchronised versions.
- State machine:
  - IDLE: on start with len≠0, latch operands, set busy and bus_req, go to REQ. On start with len=0, pulse done and stay in IDLE.
  - REQ: wait for gnt_s=1, then go to SETUP.
  - SETUP (1 cycle):
    - Drive bus_addr; _vga_mem=0; _bhe=0; strobes high.
    - In copy mode, a read phase is pending, so bus_addr=src and the next state is RD.
    - Otherwise bus_addr=dst, data_oe=1, data_out=fill word or captured word, and the next state is WR.
  - RD: _rd=0. The hold counter increments on each cycle with rdy_s=1 and clears on rdy_s=0. When the counter reaches RD_HOLD, capture data_in into the holding register, release _rd, and go to REC.
  - WR: _wr=0 with data_oe=1, using the same counter against WR_HOLD. On terminal count, release _wr, decrement the remaining count, advance both addresses by 2, and go to REC. data_oe stays high through the first REC cycle.
  - REC: all strobes and _vga_mem high for RECOVER cycles; this re-arms the VGA write edge detector. Exit:
    - remaining=0 or abort latched → DONE.
    - Otherwise, if gnt_s=0 → REQ.
    - Otherwise → SETUP.
    - In copy mode, REC after RD always returns to SETUP for the write phase.
  - DONE: drop bus_req, pulse done, clear busy, go to IDLE.
- Address arithmetic:
  - Addresses are forced even (bit 0 = 0).
  - Increment is modulo 2^ADDR_W; wrap-around is silent.
  - Overlapping copy regions are copied ascending, with no overlap correction.
- abort:
  - Latched while busy. It never truncates a strobe.
  - A copy aborted after RD finishes its paired WR first.
  - abort in IDLE has no effect.
- Bus handover:
  - Loss of grant (gnt_s=0) mid-strobe is ignored until the access completes.
  - bus_req stays asserted until DONE.
- Simultaneous start and abort in IDLE: start wins and abort is cleared.

Decomposition:
- Shared package vga_pkg holds:
  - State enum constants.
  - Mode encodings (text/320x200/320x400/640x200, also used by the VGA block).
  - The default RD_HOLD, WR_HOLD and RECOVER values, so the VGA block timing and this master stay consistent.
- One natural sub-module: vga_bus_access, which owns the SETUP/RD/WR/REC strobe sequencing and the hold counter. The top level owns operands, counts and bus request.

Test Plan:
- Fill: dst=0x00100, len=3, fill=0xA5A5, rdy tied 1, gnt after 5 cycles → three writes at 0x100, 0x102, 0x104. Each _wr low ≥ WR_HOLD+sync cycles; REC ≥ 2 cycles between writes; one done pulse; busy falls the same cycle.
- Copy with rdy stalls: src=0x00000, dst=0x04000, len=2. rdy deasserted 10 cycles mid-RD and 7 cycles mid-WR → counter restarts each time; data at dst equals the model memory; _rd/_wr never released early.
- len=0 start → done pulse 1 cycle later; bus_req never asserted.
- Wrap: dst=0x1FFFE, len=2 → writes at 0x1FFFE then 0x00000.
- Abort during the RD of word 2 of a 5-word copy → word 2 write completes, no third access, done pulses, bus_req drops.
- Reset asserted while _wr is low → next cycle: _wr=1, _vga_mem=1, bus_req=0, busy=0; a subsequent start behaves normally.
